// File: rtl/plot_arbiter_pkg.sv
// Shared definitions for the pixel-write arbiter: screen geometry, coordinate
// widths, named colours and the arbiter FSM state type.
package plot_arbiter_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  localparam int unsigned X_W   = 8;
  localparam int unsigned Y_W   = 7;
  localparam int unsigned COL_W = 3;

  localparam logic [COL_W-1:0] BLACK = 3'b000;
  localparam logic [COL_W-1:0] GREEN = 3'b010;
  localparam logic [COL_W-1:0] RED   = 3'b100;

  typedef enum logic [1:0] {
    StIdle,
    StDraw,
    StFin
  } state_e;

  // True when the (already wrapped) pixel lies inside the visible area.
  function automatic logic on_screen(logic [X_W-1:0] x, logic [Y_W-1:0] y);
    return (x < X_W'(SCREEN_W)) && (y < Y_W'(SCREEN_H));
  endfunction

endpackage

// File: rtl/plot_arbiter_rect_scanner.sv
// Row-major counter pair that walks a w x h rectangle one pixel per enabled
// clock.
//   clk_i, reset_ni : clock, synchronous active-low reset
//   start_i         : clear both counters (takes priority over en_i)
//   en_i            : advance one pixel
//   w_i, h_i        : rectangle size, must be stable while en_i is used
//   cx_o, cy_o      : current column / row offset
//   last_o          : current position is the final pixel of the rectangle
module plot_arbiter_rect_scanner
  import plot_arbiter_pkg::*;
(
  input  logic           clk_i,
  input  logic           reset_ni,
  input  logic           start_i,
  input  logic           en_i,
  input  logic [X_W-1:0] w_i,
  input  logic [Y_W-1:0] h_i,
  output logic [X_W-1:0] cx_o,
  output logic [Y_W-1:0] cy_o,
  output logic           last_o
);

  logic [X_W-1:0] cx_q, cx_d;
  logic [Y_W-1:0] cy_q, cy_d;
  logic           row_end;

  assign row_end = (cx_q == w_i - X_W'(1));
  assign last_o  = row_end && (cy_q == h_i - Y_W'(1));
  assign cx_o    = cx_q;
  assign cy_o    = cy_q;

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (start_i) begin
      cx_d = '0;
      cy_d = '0;
    end else if (en_i) begin
      if (row_end) begin
        cx_d = '0;
        cy_d = cy_q + Y_W'(1);
      end else begin
        cx_d = cx_q + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

endmodule

// File: rtl/plot_arbiter.sv
// Fixed-priority arbiter that shares the VGA pixel-write port between several
// rectangle-fill requesters and sweeps the granted rectangle one pixel/clock.
//   clk_i, reset_ni        : clock, synchronous active-low reset
//   req_i                  : per-requester request, held until done
//   rect_{x,y,w,h,colour}_i: packed per-requester rectangle, read at grant only
//   gnt_o                  : one-hot grant for the whole transaction
//   done_o                 : one-hot, one-cycle end-of-transaction pulse
//   busy_o                 : FSM not idle
//   x_out_o, y_out_o,
//   colour_out_o, plot_o   : registered VGA pixel write
module plot_arbiter
  import plot_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [NREQ-1:0]       req_i,
  input  logic [X_W*NREQ-1:0]   rect_x_i,
  input  logic [Y_W*NREQ-1:0]   rect_y_i,
  input  logic [X_W*NREQ-1:0]   rect_w_i,
  input  logic [Y_W*NREQ-1:0]   rect_h_i,
  input  logic [COL_W*NREQ-1:0] rect_colour_i,
  output logic [NREQ-1:0]       gnt_o,
  output logic [NREQ-1:0]       done_o,
  output logic                  busy_o,
  output logic [X_W-1:0]        x_out_o,
  output logic [Y_W-1:0]        y_out_o,
  output logic [COL_W-1:0]      colour_out_o,
  output logic                  plot_o
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e             state_q;
  logic [NREQ-1:0]    gnt_q, done_q;
  logic               plot_q;
  logic [X_W-1:0]     x_q, bx_q, bw_q;
  logic [Y_W-1:0]     y_q, by_q, bh_q;
  logic [COL_W-1:0]   col_q, bcol_q;

  logic               sel_valid;
  logic [IdxW-1:0]    sel_idx;
  logic [X_W-1:0]     sel_x, sel_w;
  logic [Y_W-1:0]     sel_y, sel_h;
  logic [COL_W-1:0]   sel_col;

  logic [X_W-1:0]     cx, px;
  logic [Y_W-1:0]     cy, py;
  logic               last;

  // Descending scan so the lowest set index wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        sel_valid = 1'b1;
        sel_idx   = IdxW'(i);
      end
    end
  end

  assign sel_x   = rect_x_i[sel_idx*X_W +: X_W];
  assign sel_y   = rect_y_i[sel_idx*Y_W +: Y_W];
  assign sel_w   = rect_w_i[sel_idx*X_W +: X_W];
  assign sel_h   = rect_h_i[sel_idx*Y_W +: Y_W];
  assign sel_col = rect_colour_i[sel_idx*COL_W +: COL_W];

  plot_arbiter_rect_scanner u_scanner (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .start_i  ((state_q == StIdle) && sel_valid),
    .en_i     (state_q == StDraw),
    .w_i      (bw_q),
    .h_i      (bh_q),
    .cx_o     (cx),
    .cy_o     (cy),
    .last_o   (last)
  );

  // Coordinates wrap naturally at their register widths.
  assign px = bx_q + cx;
  assign py = by_q + cy;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      done_q  <= '0;
      plot_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= BLACK;
      bx_q    <= '0;
      by_q    <= '0;
      bw_q    <= '0;
      bh_q    <= '0;
      bcol_q  <= BLACK;
    end else begin
      done_q <= '0;
      plot_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (sel_valid) begin
            bx_q    <= sel_x;
            by_q    <= sel_y;
            bw_q    <= sel_w;
            bh_q    <= sel_h;
            bcol_q  <= sel_col;
            gnt_q   <= NREQ'(1) << sel_idx;
            state_q <= ((sel_w == '0) || (sel_h == '0)) ? StFin : StDraw;
          end
        end
        StDraw: begin
          x_q    <= px;
          y_q    <= py;
          col_q  <= bcol_q;
          // Clipped pixels still take their cycle, just without a write.
          plot_q <= on_screen(px, py);
          if (last) state_q <= StFin;
        end
        StFin: begin
          done_q  <= gnt_q;
          gnt_q   <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt_o        = gnt_q;
  assign done_o       = done_q;
  assign busy_o       = (state_q != StIdle);
  assign x_out_o      = x_q;
  assign y_out_o      = y_q;
  assign colour_out_o = col_q;
  assign plot_o       = plot_q;

endmodule
